// File: rtl/clock_rate_pkg.sv
// Shared types and defaults for the clock-rate controller and its period counter.
package clock_rate_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int          CLK_DIV_WIDTH   = 28;
  localparam logic [27:0] CLK_DEFAULT_DIV = 28'd8;
  localparam logic [27:0] CLK_MIN_DIV     = 28'd2;

endpackage

// File: rtl/rate_counter.sv
// Period counter for the divided clock: counts 0..div-1, flags the wrap cycle and
// registers clock_out (high for the first floor(div/2) counts) and the start-of-period tick.
module rate_counter #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             clock_out,
  output logic             tick
);

  assign wrap = count_en && (cnt == div - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (count_en) begin
      cnt       <= wrap ? '0 : cnt + 1'b1;
      clock_out <= (cnt < (div >> 1));
      tick      <= (cnt == '0);
    end else begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_rate_controller.sv
// Run-time divide-ratio controller: divisor handshake, glitch-free ratio changes and stops.
// Optional period counter enabled by CLOCK_RATE_CTRL_PERIOD_COUNT_EN.
module clock_rate_controller
  import clock_rate_pkg::*;
#(
  parameter int               WIDTH       = CLK_DIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLK_DEFAULT_DIV),
  parameter logic [WIDTH-1:0] MIN_DIV     = WIDTH'(CLK_MIN_DIV)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             cfg_error,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] active_div,
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
  input  logic             period_clear,
  output logic [31:0]      period_count,
`endif
  output logic             running
);

  state_t           state, state_next;
  logic [WIDTH-1:0] pending_div;
  logic             pending_valid;
  logic             xfer, reject, accept, wrap;
  logic [WIDTH-1:0] cnt;

  assign running = (state != IDLE);

  rate_counter #(.WIDTH(WIDTH)) u_rate_counter (
    .clk       (clock_in),
    .rst_n     (reset_n),
    .count_en  (running),
    .div       (active_div),
    .cnt       (cnt),
    .wrap      (wrap),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always_comb begin
    state_next = state;
    cfg_ready  = (state == IDLE) || (state == RUN);
    xfer       = cfg_valid && cfg_ready;
    reject     = xfer && (cfg_divisor < MIN_DIV);
    accept     = xfer && !reject;
    unique case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN: begin
        if (accept)       state_next = enable ? PENDING : DRAIN;
        else if (!enable) state_next = DRAIN;
      end
      // A wrap always lands the pending ratio, even when enable drops that same cycle.
      PENDING: begin
        if (wrap)         state_next = enable ? RUN : DRAIN;
        else if (!enable) state_next = DRAIN;
      end
      DRAIN:   if (wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      active_div    <= DEFAULT_DIV;
      pending_div   <= '0;
      pending_valid <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_error <= reject;
      if (state == IDLE && accept) begin
        active_div <= cfg_divisor;
      end else if (wrap && pending_valid && (state == PENDING || state == DRAIN)) begin
        active_div    <= pending_div;
        pending_valid <= 1'b0;
      end
      if (state == RUN && accept) begin
        pending_div   <= cfg_divisor;
        pending_valid <= 1'b1;
      end
    end
  end

`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)          period_count <= '0;
    else if (period_clear) period_count <= '0;
    else if (tick)         period_count <= period_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_clock_rate_controller.sv
// Directed and randomized bench for clock_rate_controller against a period-position reference model.
module tb_clock_rate_controller;

  localparam int W = 28;
  localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_DRAIN = 3;

  logic         clock_in = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_divisor = '0;
  logic         cfg_ready, cfg_error, clock_out, tick, running;
  logic [W-1:0] active_div;
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
  logic         period_clear = 1'b0;
  logic [31:0]  period_count;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int win_ticks, win_highs;

  // Reference model: mode, position inside the current period, ratio in force.
  int          m_mode, m_pos, m_div, m_pend;
  bit          m_has_pend;
  bit          e_clk, e_tick, e_err;
  logic [31:0] e_pc;

  always #5 clock_in = ~clock_in;

  clock_rate_controller dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_divisor  (cfg_divisor),
    .cfg_ready    (cfg_ready),
    .cfg_error    (cfg_error),
    .clock_out    (clock_out),
    .tick         (tick),
    .active_div   (active_div),
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
    .period_clear (period_clear),
    .period_count (period_count),
`endif
    .running      (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_div = 8; m_pend = 0; m_has_pend = 0;
    e_clk = 0; e_tick = 0; e_err = 0; e_pc = 0;
  endtask

  task automatic model_edge();
    bit live, wrap, ready, bad, good;
    live  = (m_mode != M_IDLE);
    ready = (m_mode == M_IDLE) || (m_mode == M_RUN);
    bad   = cfg_valid && ready && (int'(cfg_divisor) < 2);
    good  = cfg_valid && ready && !bad;
    wrap  = live && (m_pos == m_div - 1);
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
    if (period_clear) e_pc = 0;
    else if (e_tick)  e_pc = e_pc + 32'd1;
`endif
    // High for the first floor(D/2) positions of each period; tick marks position 0.
    e_clk  = live && (m_pos < m_div / 2);
    e_tick = live && (m_pos == 0);
    e_err  = bad;
    m_pos  = (live && !wrap) ? m_pos + 1 : 0;
    case (m_mode)
      M_IDLE: begin
        if (good) m_div = int'(cfg_divisor);
        if (enable) m_mode = M_RUN;
      end
      M_RUN: begin
        if (good) begin
          m_pend = int'(cfg_divisor); m_has_pend = 1;
          m_mode = enable ? M_PEND : M_DRAIN;
        end else if (!enable) m_mode = M_DRAIN;
      end
      M_PEND: begin
        if (wrap) begin
          m_div = m_pend; m_has_pend = 0;
          m_mode = enable ? M_RUN : M_DRAIN;
        end else if (!enable) m_mode = M_DRAIN;
      end
      default: begin
        if (wrap) begin
          if (m_has_pend) begin m_div = m_pend; m_has_pend = 0; end
          m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("clock_out", 32'(clock_out), 32'(e_clk));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("cfg_error", 32'(cfg_error), 32'(e_err));
    chk("cfg_ready", 32'(cfg_ready), 32'((m_mode == M_IDLE) || (m_mode == M_RUN)));
    chk("active_div", 32'(active_div), 32'(m_div));
    chk("running", 32'(running), 32'(m_mode != M_IDLE));
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
    chk("period_count", period_count, e_pc);
`endif
  endtask

  task automatic step();
    @(posedge clock_in);
    model_edge();
    #1;
    check_all();
    if (tick) win_ticks++;
    if (clock_out) win_highs++;
    @(negedge clock_in);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_clk"}, 32'(clock_out), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_err"}, 32'(cfg_error), 0);
    chk({tag, "_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_div"}, 32'(active_div), 8);
    chk({tag, "_running"}, 32'(running), 0);
  endtask

  initial begin
    int cnt, k;
    bit ok;
    model_reset();
    repeat (3) @(negedge clock_in);
    check_reset_values("reset");
    reset_n = 1'b1;
    step();

    // Start-up latency and default period of 8.
    enable = 1'b1;
    step();
    chk("lat_edge1_clk", 32'(clock_out), 0);
    chk("lat_edge1_running", 32'(running), 1);
    step();
    chk("lat_edge2_tick", 32'(tick), 1);
    chk("lat_edge2_clk", 32'(clock_out), 1);
    win_ticks = 0; win_highs = 0;
    repeat (16) step();
    chk("div8_ticks", 32'(win_ticks), 2);
    chk("div8_highs", 32'(win_highs), 8);

    // Illegal divisor: handshake completes, error pulse, ratio unchanged.
    cfg_valid = 1'b1; cfg_divisor = 28'd1;
    step();
    cfg_valid = 1'b0;
    chk("reject_err_pulse", 32'(cfg_error), 1);
    step();
    chk("reject_err_clear", 32'(cfg_error), 0);
    win_ticks = 0; win_highs = 0;
    repeat (16) step();
    chk("reject_ticks", 32'(win_ticks), 2);
    chk("reject_highs", 32'(win_highs), 8);
    chk("reject_div", 32'(active_div), 8);

    // Mid-period change to 5.
    for (int i = 0; i < 10 && m_pos != 3; i++) step();
    cfg_valid = 1'b1; cfg_divisor = 28'd5;
    step();
    cfg_valid = 1'b0;
    chk("chg_ready_low", 32'(cfg_ready), 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (active_div == 28'd5) begin ok = 1; break; end
      step();
    end
    chk("chg_reached", 32'(ok), 1);
    chk("chg_ready_back", 32'(cfg_ready), 1);
    win_ticks = 0; win_highs = 0;
    repeat (10) step();
    chk("div5_ticks", 32'(win_ticks), 2);
    chk("div5_highs", 32'(win_highs), 4);

    // Back to 8, then stop at cnt=2.
    cfg_valid = 1'b1; cfg_divisor = 28'd8;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 20 && active_div != 28'd8; i++) step();
    repeat (8) step();
    for (int i = 0; i < 10 && m_pos != 2; i++) step();
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (!running) break;
    end
    chk("drain_cycles", 32'(cnt), 6);
    chk("drain_clk", 32'(clock_out), 0);
    chk("drain_ready", 32'(cfg_ready), 1);

    // Reset while a change is pending.
    enable = 1'b1;
    repeat (5) step();
    cfg_valid = 1'b1; cfg_divisor = 28'd5;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_low", 32'(cfg_ready), 0);
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    enable = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_reset_div", 32'(active_div), 8);

`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
    enable = 1'b1;
    period_clear = 1'b1;
    step();
    period_clear = 1'b0;
    k = 0;
    for (int i = 0; i < 200 && k < 10; i++) begin
      step();
      if (tick) k++;
    end
    step();
    chk("pc_ten", period_count, 10);
    for (int i = 0; i < 20 && !tick; i++) step();
    period_clear = 1'b1;
    step();
    period_clear = 1'b0;
    chk("pc_clear_wins", period_count, 0);
`endif

    // Randomized traffic against the model.
    enable = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_divisor = W'($urandom_range(0, 12));
`ifdef CLOCK_RATE_CTRL_PERIOD_COUNT_EN
      period_clear = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
